// File: rtl/mem_arbiter_pkg.sv
// Shared CPU definitions for the memory arbiter.
// Word width, arbiter states and latency helpers.
package mem_arbiter_pkg;

    localparam int WORD_W = 16;
    localparam int LAT_W  = 3;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        IF_WAIT,
        D_WAIT
    } arb_state_t;

    // Counter preset: writes finish next cycle, reads after lat cycles.
    function automatic logic [LAT_W-1:0] lat_preset(
        input logic we,
        input int   lat
    );
        if (we) begin
            return '0;
        end
        return LAT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_lat_cnt.sv
// Access latency down-counter for the memory arbiter.
// expire is high whenever the count has reached zero.
module arb_lat_cnt
    import mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             tick,
    output logic             expire
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    // Load on grant, otherwise count down to zero while ticking
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-port unified memory.
// Define MEMARB_PERF_EN to add the wait-cycle counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hlt,
    input  logic              if_valid,
    input  logic [WORD_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_done,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              d_valid,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_done,
    output logic [WORD_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              stall
`ifdef MEMARB_PERF_EN
    ,
    output logic [WORD_W-1:0] if_wait_cnt,
    output logic [WORD_W-1:0] d_wait_cnt
`endif
);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic             last_d_q;
    logic             last_d_d;
    logic             we_q;
    logic             we_d;
    logic             idle;
    logic             if_elig;
    logic             d_gnt;
    logic             if_gnt;
    logic             expire;
    logic             done_ok;
    logic             lat_load;
    logic [LAT_W-1:0] lat_val;

    assign idle     = (state_q == IDLE);
    assign if_elig  = if_valid & ~hlt;
    // Data wins unless it also won last time and a fetch is waiting.
    assign d_gnt    = idle & ~rst & d_valid
                    & ~(last_d_q & if_elig);
    assign if_gnt   = idle & ~rst & if_elig & ~d_gnt;
    assign done_ok  = ~idle & expire & ~rst;
    assign lat_load = d_gnt | if_gnt;
    assign lat_val  = lat_preset(d_gnt & d_we, MEM_LAT);

    arb_lat_cnt u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (lat_load),
        .load_val (lat_val),
        .tick     (~idle),
        .expire   (expire)
    );

    // Next state, grant-cycle memory drive and completion outputs
    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        we_d      = we_q;
        if_ready  = if_gnt;
        d_ready   = d_gnt;
        mem_en    = lat_load;
        mem_we    = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if_done   = 1'b0;
        d_done    = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        unique case (state_q)
            IDLE: begin
                if (d_gnt) begin
                    state_d   = D_WAIT;
                    last_d_d  = 1'b1;
                    we_d      = d_we;
                    mem_addr  = d_addr;
                    mem_wdata = d_we ? d_wdata : '0;
                end else if (if_gnt) begin
                    state_d  = IF_WAIT;
                    last_d_d = 1'b0;
                    we_d     = 1'b0;
                    mem_addr = if_addr;
                end
            end
            IF_WAIT: begin
                if_done  = done_ok;
                if_rdata = done_ok ? mem_rdata : '0;
                if (expire) begin
                    state_d = IDLE;
                end
            end
            D_WAIT: begin
                d_done  = done_ok;
                d_rdata = (done_ok & ~we_q) ? mem_rdata : '0;
                if (expire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, priority history and access-type registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            we_q     <= we_d;
        end
    end

    assign stall = (d_valid & ~d_ready)
                 | ((state_q == D_WAIT) & ~d_done);

`ifdef MEMARB_PERF_EN
    logic [WORD_W-1:0] if_wait_q;
    logic [WORD_W-1:0] if_wait_d;
    logic [WORD_W-1:0] d_wait_q;
    logic [WORD_W-1:0] d_wait_d;

    // Saturating increments for requests left waiting this cycle
    always_comb begin
        if_wait_d = if_wait_q;
        d_wait_d  = d_wait_q;
        if (if_valid & ~if_ready & ~(&if_wait_q)) begin
            if_wait_d = if_wait_q + WORD_W'(1);
        end
        if (d_valid & ~d_ready & ~(&d_wait_q)) begin
            d_wait_d = d_wait_q + WORD_W'(1);
        end
    end

    // Wait-cycle counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            if_wait_q <= '0;
            d_wait_q  <= '0;
        end else begin
            if_wait_q <= if_wait_d;
            d_wait_q  <= d_wait_d;
        end
    end

    assign if_wait_cnt = if_wait_q;
    assign d_wait_cnt  = d_wait_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT 2 and 3) share
// stimulus; a transaction-level model predicts every output.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hlt = 1'b0;
    logic        if_valid = 1'b0;
    logic        d_valid = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] if_addr = '0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] junk = '0;

    logic        if_ready_w [2];
    logic        if_done_w  [2];
    logic        d_ready_w  [2];
    logic        d_done_w   [2];
    logic        mem_en_w   [2];
    logic        mem_we_w   [2];
    logic        stall_w    [2];
    logic [15:0] if_rdata_w [2];
    logic [15:0] d_rdata_w  [2];
    logic [15:0] mem_addr_w [2];
    logic [15:0] mem_wdata_w[2];
    logic [15:0] mem_rdata_w[2];
`ifdef MEMARB_PERF_EN
    logic [15:0] if_wc_w[2];
    logic [15:0] d_wc_w [2];
`endif

    int checks = 0;
    int failures = 0;

    bit          pend  [2];
    bit          pk_d  [2];
    bit          pwe   [2];
    bit          last_d[2];
    logic [15:0] paddr [2];
    int          due   [2];
    logic [15:0] ifc   [2];
    logic [15:0] dc    [2];
    int          cyc = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] rdfn(input logic [15:0] a);
        if (a == 16'h0010) return 16'hA5A5;
        return (a ^ 16'h3C5A) + 16'h0101;
    endfunction

    always @(posedge clk) junk <= 16'($urandom);

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = g + 2;
        logic [16:0] pipe[LAT];

        mem_arbiter #(.MEM_LAT(LAT)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .hlt       (hlt),
            .if_valid  (if_valid),
            .if_addr   (if_addr),
            .if_ready  (if_ready_w[g]),
            .if_done   (if_done_w[g]),
            .if_rdata  (if_rdata_w[g]),
            .d_valid   (d_valid),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_ready   (d_ready_w[g]),
            .d_done    (d_done_w[g]),
            .d_rdata   (d_rdata_w[g]),
            .mem_en    (mem_en_w[g]),
            .mem_we    (mem_we_w[g]),
            .mem_addr  (mem_addr_w[g]),
            .mem_wdata (mem_wdata_w[g]),
            .mem_rdata (mem_rdata_w[g]),
            .stall     (stall_w[g])
`ifdef MEMARB_PERF_EN
            ,
            .if_wait_cnt (if_wc_w[g]),
            .d_wait_cnt  (d_wc_w[g])
`endif
        );

        // Memory: read data valid only at grant + LAT, junk otherwise
        always @(posedge clk) begin
            pipe[0] <= {mem_en_w[g] & ~mem_we_w[g], mem_addr_w[g]};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata_w[g] = pipe[LAT-1][16]
                              ? rdfn(pipe[LAT-1][15:0]) : junk;
    end

    task automatic chk(input string tag, input int inst,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] obs=%0h exp=%0h",
                   tag, inst, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit gd, gi, wi, dn, wr;
            logic [15:0] ea;
            gd = 1'b0;
            gi = 1'b0;
            wi = if_valid && !hlt;
            if (!pend[i] && !rst) begin
                if (d_valid && wi) begin
                    gd = !last_d[i];
                    gi = last_d[i];
                end else begin
                    gd = d_valid;
                    gi = wi;
                end
            end
            wr = gd && d_we;
            dn = pend[i] && (cyc == due[i]) && !rst;
            ea = gd ? d_addr : (gi ? if_addr : 16'h0);
            chk("d_ready", i, d_ready_w[i], gd);
            chk("if_ready", i, if_ready_w[i], gi);
            chk("mem_en", i, mem_en_w[i], gd | gi);
            chk("mem_we", i, mem_we_w[i], wr);
            chk("mem_addr", i, mem_addr_w[i], ea);
            chk("mem_wdata", i, mem_wdata_w[i],
                wr ? d_wdata : 16'h0);
            chk("if_done", i, if_done_w[i], dn && !pk_d[i]);
            chk("d_done", i, d_done_w[i], dn && pk_d[i]);
            chk("if_rdata", i, if_rdata_w[i],
                (dn && !pk_d[i]) ? rdfn(paddr[i]) : 16'h0);
            chk("d_rdata", i, d_rdata_w[i],
                (dn && pk_d[i] && !pwe[i]) ? rdfn(paddr[i]) : 16'h0);
            chk("stall", i, stall_w[i],
                (d_valid && !gd) || (pend[i] && pk_d[i] && !dn));
`ifdef MEMARB_PERF_EN
            chk("if_wait_cnt", i, if_wc_w[i], ifc[i]);
            chk("d_wait_cnt", i, d_wc_w[i], dc[i]);
`endif
            if (rst) begin
                pend[i]   = 1'b0;
                last_d[i] = 1'b0;
                ifc[i]    = '0;
                dc[i]     = '0;
            end else begin
                if (if_valid && !gi && ifc[i] != 16'hFFFF) ifc[i]++;
                if (d_valid && !gd && dc[i] != 16'hFFFF) dc[i]++;
                if (dn) pend[i] = 1'b0;
                if (gd || gi) begin
                    pend[i]   = 1'b1;
                    pk_d[i]   = gd;
                    pwe[i]    = wr;
                    paddr[i]  = ea;
                    due[i]    = cyc + (wr ? 1 : i + 2);
                    last_d[i] = gd;
                end
            end
        end
        cyc++;
    endtask

    task automatic step(input bit r, input bit h, input bit iv,
                        input logic [15:0] ia, input bit dv,
                        input bit dw, input logic [15:0] da,
                        input logic [15:0] dwd);
        @(posedge clk);
        #1;
        rst = r;
        hlt = h;
        if_valid = iv;
        if_addr = ia;
        d_valid = dv;
        d_we = dw;
        d_addr = da;
        d_wdata = dwd;
        @(negedge clk);
        model_step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_zero(input string tag, input int i);
        chk({tag, "_if_ready"}, i, if_ready_w[i], 0);
        chk({tag, "_d_ready"}, i, d_ready_w[i], 0);
        chk({tag, "_if_done"}, i, if_done_w[i], 0);
        chk({tag, "_d_done"}, i, d_done_w[i], 0);
        chk({tag, "_mem_en"}, i, mem_en_w[i], 0);
        chk({tag, "_mem_we"}, i, mem_we_w[i], 0);
        chk({tag, "_mem_addr"}, i, mem_addr_w[i], 0);
        chk({tag, "_mem_wdata"}, i, mem_wdata_w[i], 0);
        chk({tag, "_if_rdata"}, i, if_rdata_w[i], 0);
        chk({tag, "_d_rdata"}, i, d_rdata_w[i], 0);
        chk({tag, "_stall"}, i, stall_w[i], 0);
    endtask

    initial begin
        bit [2:0] seq;
        int ng;
        repeat (2) @(posedge clk);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk_zero("rst", 0);
        chk_zero("rst", 1);

        step(0, 0, 1, 16'h0010, 0, 0, 0, 0);
        chk("f_en_c0", 0, mem_en_w[0], 1);
        chk("f_addr_c0", 0, mem_addr_w[0], 16'h0010);
        step(0, 0, 1, 16'h0010, 0, 0, 0, 0);
        chk("f_en_c1", 0, mem_en_w[0], 0);
        step(0, 0, 1, 16'h0010, 0, 0, 0, 0);
        chk("f_done_c2", 0, if_done_w[0], 1);
        chk("f_rdata_c2", 0, if_rdata_w[0], 16'hA5A5);
        step(0, 0, 1, 16'h0010, 0, 0, 0, 0);
        chk("f_ready_c3", 0, if_ready_w[0], 1);
        idle(6);

        step(0, 0, 1, 16'h0044, 1, 0, 16'h0200, 0);
        chk("pri_d_ready", 0, d_ready_w[0], 1);
        chk("pri_if_ready", 0, if_ready_w[0], 0);
        chk("pri_addr", 0, mem_addr_w[0], 16'h0200);
        step(0, 0, 1, 16'h0044, 0, 0, 0, 0);
        chk("pri_stall_c1", 0, stall_w[0], 1);
        step(0, 0, 1, 16'h0044, 0, 0, 0, 0);
        chk("pri_d_done", 0, d_done_w[0], 1);
        chk("pri_stall_c2", 0, stall_w[0], 0);
        step(0, 0, 1, 16'h0044, 0, 0, 0, 0);
        chk("pri_if_gnt", 0, if_ready_w[0], 1);
        chk("pri_if_addr", 0, mem_addr_w[0], 16'h0044);
        idle(6);

        step(1, 0, 0, 0, 0, 0, 0, 0);
        seq = '0;
        ng = 0;
        for (int c = 0; c < 8; c++) begin
            step(0, 0, 1, 16'h0080, 1, 0, 16'h0400, 0);
            if (mem_en_w[0]) begin
                seq = {seq[1:0], mem_addr_w[0] == 16'h0400};
                ng++;
            end
        end
        chk("alt_count", 0, ng, 3);
        chk("alt_seq", 0, seq, 3'b101);
        idle(6);

        step(0, 0, 0, 0, 1, 1, 16'h0300, 16'h1234);
        chk("st_we", 0, mem_we_w[0], 1);
        chk("st_wdata", 0, mem_wdata_w[0], 16'h1234);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("st_done", 0, d_done_w[0], 1);
        chk("st_rdata", 0, d_rdata_w[0], 0);
        chk("st_we_off", 0, mem_we_w[0], 0);
        idle(3);

        step(0, 0, 0, 0, 1, 0, 16'h0500, 0);
        chk("rm_gnt", 1, mem_en_w[1], 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0);
            chk_zero("rm", 1);
        end

        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 1, 16'h0066, 0, 0, 0, 0);
            chk("hlt_if_ready", 0, if_ready_w[0], 0);
            chk("hlt_if_ready", 1, if_ready_w[1], 0);
        end
        step(0, 1, 1, 16'h0066, 1, 0, 16'h0700, 0);
        chk("hlt_d_ready", 0, d_ready_w[0], 1);
`ifdef MEMARB_PERF_EN
        chk("hlt_wait_cnt", 0, if_wc_w[0], 5);
`endif
        idle(6);

        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1,
                 16'($urandom),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0,
                 16'($urandom),
                 16'($urandom));
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
